// File: rtl/pwm_cmd_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_cmd_pkg: frame header, command codes, response codes, FSM states      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package pwm_cmd_pkg;

  localparam logic [7:0] c_HEADER         = 8'hA5;
  localparam logic [7:0] c_CMD_SET_PERIOD = 8'h01;
  localparam logic [7:0] c_CMD_SET_DUTY   = 8'h02;
  localparam logic [7:0] c_CMD_SET_STEP   = 8'h03;
  localparam logic [7:0] c_ACK            = 8'h06;
  localparam logic [7:0] c_NAK            = 8'h15;

  typedef logic [2:0] state_t;

  localparam state_t c_ST_IDLE    = 3'd0;
  localparam state_t c_ST_GET_CMD = 3'd1;
  localparam state_t c_ST_GET_HI  = 3'd2;
  localparam state_t c_ST_GET_LO  = 3'd3;
  localparam state_t c_ST_RESP    = 3'd4;

endpackage
`default_nettype wire

// File: rtl/pwm_cmd_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_cmd_ctrl_if: byte stream from the UART receiver and response path     |
// | back to the UART transmitter.                                             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface pwm_cmd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // UART side
  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  // controller side
  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface
`default_nettype wire

// File: rtl/pwm_cmd_ctrl_ramp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_duty_ramp: on each pwm_sync, moves duty toward min(target, limit) by  |
// | at most one step (step 0 jumps straight there).                           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pwm_duty_ramp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sync,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] duty
);

  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] w_tgt;
  logic [WIDTH:0]   w_delta;
  logic             w_up;
  logic [WIDTH-1:0] w_next;

  // A step is taken only when the distance exceeds it, so duty +/- step
  // always lands strictly between duty and the target and cannot wrap.
  always_comb begin
    w_tgt   = (target < limit) ? target : limit;
    w_up    = (w_tgt >= r_duty);
    w_delta = w_up ? ({1'b0, w_tgt} - {1'b0, r_duty})
                   : ({1'b0, r_duty} - {1'b0, w_tgt});
    w_next  = w_tgt;
    if (step != '0 && w_delta > {1'b0, step}) begin
      w_next = w_up ? (r_duty + step) : (r_duty - step);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
    end else if (sync) begin
      r_duty <= w_next;
    end
  end

  assign duty = r_duty;

endmodule
`default_nettype wire

// File: rtl/pwm_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_cmd_ctrl: parses A5/CMD/HI/LO frames, holds pending PWM settings,     |
// | commits them on pwm_sync and answers each frame with ACK/NAK.             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pwm_cmd_ctrl
  import pwm_cmd_pkg::*;
#(
  parameter int               WIDTH          = 16,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(1000),
  parameter int               TIMEOUT        = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  pwm_cmd_ctrl_if.slave     uart,
  input  logic              pwm_sync,
  output logic [WIDTH-1:0]  period_out,
  output logic [WIDTH-1:0]  duty_out,
  output logic              busy
);

  localparam int                 c_GAP_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(TIMEOUT);

  state_t             r_state;
  logic [7:0]         r_cmd;
  logic [7:0]         r_hi;
  logic [c_GAP_W-1:0] r_gap;
  logic [WIDTH-1:0]   r_pend_period;
  logic [WIDTH-1:0]   r_target;
  logic [WIDTH-1:0]   r_step;
  logic [WIDTH-1:0]   r_period;
  logic               r_tx_valid;
  logic [7:0]         r_tx_data;

  logic [15:0]        w_raw;
  logic [WIDTH-1:0]   w_payload;

  assign w_raw = {r_hi, uart.rx_data};

  generate
    if (WIDTH > 16) begin : g_zext
      assign w_payload = {{(WIDTH-16){1'b0}}, w_raw};
    end else if (WIDTH == 16) begin : g_exact
      assign w_payload = w_raw;
    end else begin : g_trunc
      assign w_payload = w_raw[WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_ST_IDLE;
      r_cmd         <= 8'h00;
      r_hi          <= 8'h00;
      r_gap         <= '0;
      r_pend_period <= DEFAULT_PERIOD;
      r_target      <= '0;
      r_step        <= '0;
      r_period      <= DEFAULT_PERIOD;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= 8'h00;
    end else begin
      // Nonblocking read of r_pend_period: a write in this same cycle waits
      // for the next sync.
      if (pwm_sync) begin
        r_period <= r_pend_period;
      end

      case (r_state)
        c_ST_IDLE: begin
          r_gap <= '0;
          if (uart.rx_valid && uart.rx_data == c_HEADER) begin
            r_state <= c_ST_GET_CMD;
          end
        end

        c_ST_GET_CMD, c_ST_GET_HI, c_ST_GET_LO: begin
          if (uart.rx_valid) begin
            r_gap <= '0;
            if (r_state == c_ST_GET_CMD) begin
              r_cmd   <= uart.rx_data;
              r_state <= c_ST_GET_HI;
            end else if (r_state == c_ST_GET_HI) begin
              r_hi    <= uart.rx_data;
              r_state <= c_ST_GET_LO;
            end else begin
              r_state    <= c_ST_RESP;
              r_tx_valid <= 1'b1;
              r_tx_data  <= c_ACK;
              case (r_cmd)
                c_CMD_SET_PERIOD: begin
                  if (w_payload == '0) begin
                    r_tx_data <= c_NAK;
                  end else begin
                    r_pend_period <= w_payload;
                  end
                end
                c_CMD_SET_DUTY: r_target  <= w_payload;
                c_CMD_SET_STEP: r_step    <= w_payload;
                default:        r_tx_data <= c_NAK;
              endcase
            end
          end else if (r_gap == c_GAP_MAX) begin
            // silent abandon: no response, nothing written
            r_state <= c_ST_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end

        c_ST_RESP: begin
          if (r_tx_valid && uart.tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= c_ST_IDLE;
          end
        end

        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  pwm_duty_ramp #(
    .WIDTH (WIDTH)
  ) u_ramp (
    .clk    (clk),
    .rst_n  (rst_n),
    .sync   (pwm_sync),
    .target (r_target),
    .limit  (r_pend_period),
    .step   (r_step),
    .duty   (duty_out)
  );

  assign period_out    = r_period;
  assign uart.tx_valid = r_tx_valid;
  assign uart.tx_data  = r_tx_data;
  assign busy          = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pwm_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pwm_cmd_ctrl: vector table, directed corner sequences and randomized   |
// | frames/syncs against an arithmetic reference model.                       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_pwm_cmd_ctrl;

  localparam int c_TIMEOUT = 20;

  logic        clk;
  logic        rst_n;
  logic        pwm_sync;
  logic [15:0] period_out;
  logic [15:0] duty_out;
  logic        busy;

  pwm_cmd_ctrl_if u_if ();

  pwm_cmd_ctrl #(
    .WIDTH          (16),
    .DEFAULT_PERIOD (16'd1000),
    .TIMEOUT        (c_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart       (u_if),
    .pwm_sync   (pwm_sync),
    .period_out (period_out),
    .duty_out   (duty_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_pend, m_target, m_step, m_period, m_duty;

  typedef struct {
    bit          send;
    logic [7:0]  cmd;
    logic [15:0] payload;
    logic [7:0]  resp;
    int          syncs;
    logic [15:0] period;
    logic [15:0] duty;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    u_if.rx_data  = b;
    u_if.rx_valid = 1'b1;
    tick();
    u_if.rx_valid = 1'b0;
  endtask

  task automatic pulse_sync();
    pwm_sync = 1'b1;
    tick();
    pwm_sync = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  function automatic void model_reset();
    m_pend = 1000; m_target = 0; m_step = 0; m_period = 1000; m_duty = 0;
  endfunction

  // commit rule from the controller description, in plain integers
  function automatic void model_sync();
    int tgt, d;
    tgt = (m_target < m_pend) ? m_target : m_pend;
    d   = tgt - m_duty;
    if (m_step == 0 || (d < 0 ? -d : d) <= m_step) m_duty = tgt;
    else if (d > 0) m_duty = m_duty + m_step;
    else m_duty = m_duty - m_step;
    m_period = m_pend;
  endfunction

  function automatic logic [7:0] model_frame(input logic [7:0] cmd, input int payload);
    if (cmd == 8'h01) begin
      if (payload == 0) return 8'h15;
      m_pend = payload;
      return 8'h06;
    end else if (cmd == 8'h02) begin
      m_target = payload;
      return 8'h06;
    end else if (cmd == 8'h03) begin
      m_step = payload;
      return 8'h06;
    end
    return 8'h15;
  endfunction

  task automatic get_resp(input string name, input logic [7:0] exp);
    int i;
    i = 0;
    while (!u_if.tx_valid && i < 20) begin
      tick();
      i++;
    end
    if (!u_if.tx_valid) begin
      check({name, "_resp_timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, "_resp"}, u_if.tx_data, exp);
      u_if.tx_ready = 1'b1;
      tick();
      u_if.tx_ready = 1'b0;
      check({name, "_busy_after"}, busy, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] payload, input int gap);
    send_byte(8'hA5);
    repeat (gap) tick();
    send_byte(cmd);
    repeat (gap) tick();
    send_byte(payload[15:8]);
    repeat (gap) tick();
    send_byte(payload[7:0]);
  endtask

  initial begin
    logic [7:0] saved;
    bit         stable;
    logic [7:0] cmd;
    int         pl;
    logic [7:0] exp;

    rst_n         = 1'b0;
    pwm_sync      = 1'b0;
    u_if.rx_data  = 8'h00;
    u_if.rx_valid = 1'b0;
    u_if.tx_ready = 1'b0;

    tbl[0]  = '{1'b1, 8'h01, 16'h00C8, 8'h06, 1, 16'd200, 16'd0};
    tbl[1]  = '{1'b1, 8'h02, 16'h0064, 8'h06, 1, 16'd200, 16'd100};
    tbl[2]  = '{1'b1, 8'h02, 16'h0000, 8'h06, 1, 16'd200, 16'd0};
    tbl[3]  = '{1'b1, 8'h03, 16'h0019, 8'h06, 0, 16'd200, 16'd0};
    tbl[4]  = '{1'b1, 8'h02, 16'h0064, 8'h06, 1, 16'd200, 16'd25};
    tbl[5]  = '{1'b0, 8'h00, 16'h0000, 8'h00, 1, 16'd200, 16'd50};
    tbl[6]  = '{1'b0, 8'h00, 16'h0000, 8'h00, 1, 16'd200, 16'd75};
    tbl[7]  = '{1'b0, 8'h00, 16'h0000, 8'h00, 1, 16'd200, 16'd100};
    tbl[8]  = '{1'b0, 8'h00, 16'h0000, 8'h00, 1, 16'd200, 16'd100};
    tbl[9]  = '{1'b1, 8'h03, 16'h0000, 8'h06, 0, 16'd200, 16'd100};
    tbl[10] = '{1'b1, 8'h02, 16'h0300, 8'h06, 1, 16'd200, 16'd200};
    tbl[11] = '{1'b1, 8'h01, 16'h0000, 8'h15, 1, 16'd200, 16'd200};
    tbl[12] = '{1'b1, 8'h7F, 16'h1234, 8'h15, 1, 16'd200, 16'd200};
    tbl[13] = '{1'b1, 8'h01, 16'h0064, 8'h06, 1, 16'd100, 16'd100};
    tbl[14] = '{1'b1, 8'h03, 16'h000A, 8'h06, 0, 16'd100, 16'd100};
    tbl[15] = '{1'b1, 8'h02, 16'h0050, 8'h06, 1, 16'd100, 16'd90};
    tbl[16] = '{1'b0, 8'h00, 16'h0000, 8'h00, 1, 16'd100, 16'd80};
    tbl[17] = '{1'b0, 8'h00, 16'h0000, 8'h00, 1, 16'd100, 16'd80};

    do_reset();
    repeat (5) pulse_sync();
    check("reset_period", period_out, 16'd1000);
    check("reset_duty", duty_out, 16'd0);
    check("reset_tx_valid", u_if.tx_valid, 1'b0);
    check("reset_busy", busy, 1'b0);

    for (int i = 0; i < 18; i++) begin
      if (tbl[i].send) begin
        send_frame(tbl[i].cmd, tbl[i].payload, 0);
        get_resp($sformatf("vec%0d", i), tbl[i].resp);
      end
      repeat (tbl[i].syncs) pulse_sync();
      tick();
      check($sformatf("vec%0d_period", i), period_out, tbl[i].period);
      check($sformatf("vec%0d_duty", i), duty_out, tbl[i].duty);
    end

    // pending write landing on the same cycle as pwm_sync: old value commits
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    u_if.rx_data  = 8'h96;
    u_if.rx_valid = 1'b1;
    pwm_sync      = 1'b1;
    tick();
    u_if.rx_valid = 1'b0;
    pwm_sync      = 1'b0;
    check("same_cycle_old_period", period_out, 16'd100);
    get_resp("same_cycle", 8'h06);
    pulse_sync();
    check("same_cycle_new_period", period_out, 16'd150);
    check("same_cycle_duty", duty_out, 16'd80);

    // inter-byte timeout abandons the frame silently
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (c_TIMEOUT + 5) tick();
    check("timeout_busy", busy, 1'b0);
    send_byte(8'h00);
    send_byte(8'hC8);
    repeat (5) tick();
    check("timeout_no_resp", u_if.tx_valid, 1'b0);
    pulse_sync();
    check("timeout_period", period_out, 16'd150);

    // slow frame still inside the timeout window
    send_frame(8'h02, 16'h0046, c_TIMEOUT - 3);
    get_resp("slow_frame", 8'h06);
    pulse_sync();
    check("slow_frame_duty", duty_out, 16'd70);

    // back-pressure with stray bytes arriving in RESP
    send_frame(8'h02, 16'h003C, 0);
    saved  = u_if.tx_data;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      u_if.rx_data  = (i % 2 == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      u_if.rx_valid = 1'b1;
      tick();
      if (!u_if.tx_valid || u_if.tx_data !== saved) stable = 1'b0;
    end
    u_if.rx_valid = 1'b0;
    check("backpressure_stable", stable, 1'b1);
    get_resp("backpressure", 8'h06);
    tick();
    check("stray_bytes_dropped", busy, 1'b0);
    pulse_sync();
    check("backpressure_duty", duty_out, 16'd60);

    // reset while a response is pending
    send_frame(8'h03, 16'h0005, 0);
    check("pre_reset_tx_valid", u_if.tx_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx_valid", u_if.tx_valid, 1'b0);
    check("async_reset_tx_data", u_if.tx_data, 8'h00);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_period", period_out, 16'd1000);
    check("async_reset_duty", duty_out, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    model_reset();

    // randomized frames and syncs against the reference model
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 4))
          0: cmd = 8'h01;
          1: cmd = 8'h02;
          2: cmd = 8'h03;
          3: cmd = 8'h7F;
          default: cmd = 8'($urandom_range(4, 255));
        endcase
        if (cmd == 8'h01)
          pl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 400));
        else if (cmd == 8'h02)
          pl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 500));
        else
          pl = int'($urandom_range(0, 60));
        exp = model_frame(cmd, pl);
        send_frame(cmd, 16'(pl), int'($urandom_range(0, 3)));
        get_resp($sformatf("rand%0d", it), exp);
      end else begin
        model_sync();
        pulse_sync();
        check($sformatf("rand%0d_period", it), period_out, 32'(m_period));
        check($sformatf("rand%0d_duty", it), duty_out, 32'(m_duty));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pwm_cmd_ctrl.md
# pwm_cmd_ctrl

Command-driven configuration controller for the center-aligned PWM generator. Parses 4-byte command frames from the UART receiver and holds pending period and duty values. It commits them to the PWM only at triangle-cycle boundaries, optionally slewing duty toward its target, and returns a one-byte ACK/NAK to the UART transmitter. It sits between the UART RX/TX pair and the `pwm` instance.

## Interface
- WIDTH, 16, period/duty width (matches PWM counter)
- DEFAULT_PERIOD, 16'd1000, period_out value after reset
- TIMEOUT, 50000, max clk cycles between bytes of one frame
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  received byte
- rx_valid  input  1  one-cycle strobe, rx_data valid
- tx_data  output  8  response byte
- tx_valid  output  1  response available; held until accepted
- tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready
- pwm_sync  input  1  one-cycle strobe at PWM counter == 0 (cycle boundary)
- period_out  output  WIDTH  active period to PWM
- duty_out  output  WIDTH  active duty to PWM
- busy  output  1  frame in progress or response pending

## Operation
- Frame: 0xA5, CMD, D_HI, D_LO. Payload is {D_HI, D_LO}, truncated or zero-extended to WIDTH.
- CMD 0x01 SET_PERIOD: payload 0 -> NAK, else pend_period <= payload, ACK.
- CMD 0x02 SET_DUTY: target_duty <= payload, ACK.
- CMD 0x03 SET_STEP: ramp_step <= payload, ACK. Step 0 means an immediate jump.
- Any other CMD -> NAK, no register change.
- FSM states: IDLE, GET_CMD, GET_HI, GET_LO, RESP.
- IDLE: waits for rx_valid with byte 0xA5 -> GET_CMD. Other bytes are ignored.
- GET_CMD, GET_HI, GET_LO: each rx_valid advances one state. GET_LO goes to RESP.
- In any GET_* state, a byte gap exceeding TIMEOUT cycles (gap counter reloads on each accepted byte) -> IDLE. No response and no register change.
- RESP: tx_valid = 1 with tx_data = 0x06 (ACK) or 0x15 (NAK). The handshake returns the FSM to IDLE.
- rx bytes arriving in RESP are dropped.
- busy = 1 in every state except IDLE.
- Commit at pwm_sync:
  - period_out <= pend_period.
  - Let tgt = min(target_duty, pend_period).
  - If ramp_step == 0 or |tgt - duty_out| <= ramp_step: duty_out <= tgt.
  - Otherwise duty_out moves by ramp_step toward tgt.
- Ramp arithmetic uses WIDTH+1 bits and never wraps.
- Reset values: period_out = DEFAULT_PERIOD, pend_period = DEFAULT_PERIOD, duty_out = 0, target_duty = 0, ramp_step = 0, tx_valid = 0, tx_data = 0x00, busy = 0, FSM = IDLE.

## Timing
- D_LO accepted at cycle N: pending registers update and tx_valid rises at N+1, both registered.
- tx_valid and tx_data stay stable until the tx_ready handshake. FSM = IDLE the cycle after the handshake.
- pwm_sync at cycle S: period_out and duty_out change at S+1. Between syncs they hold.
- A pending write and pwm_sync in the same cycle: the commit uses the old pending value. The new value commits at the next sync.
- Ramp advances at most one step per pwm_sync.
- Reset asserted mid-frame or mid-response: all state returns to reset values immediately, and tx_valid drops asynchronously.
- TIMEOUT counter: saturating, width $clog2(TIMEOUT+1).

## Structure
- Package pwm_cmd_pkg: header constant 0xA5, CMD_SET_PERIOD/DUTY/STEP codes, ACK 0x06 / NAK 0x15, FSM state enum.
- Sub-module pwm_duty_ramp: the combinational/registered slew of duty_out toward the clamped target on pwm_sync. The parser FSM stays in the top level.

## Test plan
- Reset, then 5 pwm_sync pulses -> period_out = 1000, duty_out = 0, tx_valid = 0, busy = 0.
- Frame A5 01 00 C8 then A5 02 00 64 with step 0 -> two ACKs (0x06). After the next pwm_sync: period_out = 200, duty_out = 100.
- Step 25 (A5 03 00 19), then duty target 100 from 0 -> duty_out sequence 25, 50, 75, 100 on successive syncs, then holds.
- Duty target 0x0300 with period 200 -> duty_out clamps to 200. A5 01 00 00 -> NAK, period unchanged.
- A5 01, then silence for TIMEOUT+1 cycles, then 00 C8 -> no response, period unchanged, busy = 0 after timeout. Unknown CMD 0x7F -> NAK.
- tx_ready held low for 10 cycles in RESP, with stray rx bytes -> tx_data stable, bytes dropped. rst_n pulsed mid-frame -> all outputs at reset values.
